// File: rtl/yarvi_alu_arb_if.sv
// Handshake bundle between two ALU requesters and the shared-ALU arbiter.
// master = requester side, slave = arbiter side.
interface yarvi_alu_arb_if #(
    parameter int XLEN = 32
);
    logic            req0_valid;
    logic            req0_ready;
    logic            req0_insn30;
    logic [2:0]      req0_funct3;
    logic [XLEN-1:0] req0_op1;
    logic [XLEN-1:0] req0_op2;
    logic            rsp0_valid;
    logic            rsp0_ready;
    logic [XLEN-1:0] rsp0_result;

    logic            req1_valid;
    logic            req1_ready;
    logic            req1_insn30;
    logic [2:0]      req1_funct3;
    logic [XLEN-1:0] req1_op1;
    logic [XLEN-1:0] req1_op2;
    logic            rsp1_valid;
    logic            rsp1_ready;
    logic [XLEN-1:0] rsp1_result;

    modport master (
        output req0_valid, req0_insn30, req0_funct3, req0_op1, req0_op2, rsp0_ready,
        input  req0_ready, rsp0_valid, rsp0_result,
        output req1_valid, req1_insn30, req1_funct3, req1_op1, req1_op2, rsp1_ready,
        input  req1_ready, rsp1_valid, rsp1_result
    );

    modport slave (
        input  req0_valid, req0_insn30, req0_funct3, req0_op1, req0_op2, rsp0_ready,
        output req0_ready, rsp0_valid, rsp0_result,
        input  req1_valid, req1_insn30, req1_funct3, req1_op1, req1_op2, rsp1_ready,
        output req1_ready, rsp1_valid, rsp1_result
    );
endinterface

// File: rtl/yarvi_alu_arb.sv
// Two-requester front end sharing one combinational RV32 ALU; round-robin grant,
// one registered result slot per requester.
module yarvi_alu #(
    parameter int XLEN = 32
) (
    input  logic            insn30,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] result
);
    logic [4:0] shamt;

    assign shamt = op2[4:0];

    always_comb begin
        result = '0;
        case (funct3)
            3'd0: result = insn30 ? (op1 - op2) : (op1 + op2);
            3'd1: result = op1 << shamt;
            3'd2: result = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            3'd3: result = {{(XLEN-1){1'b0}}, (op1 < op2)};
            3'd4: result = op1 ^ op2;
            3'd5: result = insn30 ? $unsigned($signed(op1) >>> shamt) : (op1 >> shamt);
            3'd6: result = op1 | op2;
            default: result = op1 & op2;
        endcase
    end
endmodule

module yarvi_alu_arb #(
    parameter int XLEN = 32
) (
    input  logic clock,
    input  logic reset_n,
    yarvi_alu_arb_if.slave bus
);
    logic            prio;
    logic            elig0;
    logic            elig1;
    logic            grant0;
    logic            grant1;
    logic            alu_insn30;
    logic [2:0]      alu_funct3;
    logic [XLEN-1:0] alu_op1;
    logic [XLEN-1:0] alu_op2;
    logic [XLEN-1:0] alu_result;
    logic            slot0_valid;
    logic            slot1_valid;
    logic [XLEN-1:0] slot0_result;
    logic [XLEN-1:0] slot1_result;

    // A slot that is being drained this cycle can be refilled in the same cycle.
    always_comb begin
        elig0  = bus.req0_valid && (!slot0_valid || bus.rsp0_ready);
        elig1  = bus.req1_valid && (!slot1_valid || bus.rsp1_ready);
        grant0 = elig0 && (!elig1 || !prio);
        grant1 = elig1 && (!elig0 || prio);
    end

    // Ready is masked during reset only at the port; the grant feeding the slots
    // needs no masking because the flops are held in reset anyway.
    assign bus.req0_ready  = grant0 && reset_n;
    assign bus.req1_ready  = grant1 && reset_n;
    assign bus.rsp0_valid  = slot0_valid;
    assign bus.rsp1_valid  = slot1_valid;
    assign bus.rsp0_result = slot0_result;
    assign bus.rsp1_result = slot1_result;

    always_comb begin
        if (grant1) begin
            alu_insn30 = bus.req1_insn30;
            alu_funct3 = bus.req1_funct3;
            alu_op1    = bus.req1_op1;
            alu_op2    = bus.req1_op2;
        end else begin
            alu_insn30 = bus.req0_insn30;
            alu_funct3 = bus.req0_funct3;
            alu_op1    = bus.req0_op1;
            alu_op2    = bus.req0_op2;
        end
    end

    yarvi_alu #(
        .XLEN(XLEN)
    ) alu (
        .insn30(alu_insn30),
        .funct3(alu_funct3),
        .op1   (alu_op1),
        .op2   (alu_op2),
        .result(alu_result)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio         <= 1'b0;
            slot0_valid  <= 1'b0;
            slot1_valid  <= 1'b0;
            slot0_result <= '0;
            slot1_result <= '0;
        end else begin
            if (grant0) begin
                slot0_valid  <= 1'b1;
                slot0_result <= alu_result;
            end else if (slot0_valid && bus.rsp0_ready) begin
                slot0_valid <= 1'b0;
            end

            if (grant1) begin
                slot1_valid  <= 1'b1;
                slot1_result <= alu_result;
            end else if (slot1_valid && bus.rsp1_ready) begin
                slot1_valid <= 1'b0;
            end

            // Pointer moves to the other requester after every grant.
            if (grant0) begin
                prio <= 1'b1;
            end else if (grant1) begin
                prio <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_yarvi_alu_arb.sv
// Directed and randomized check of yarvi_alu_arb against a behavioural model of
// the arbitration rules and RV32 ALU arithmetic.
module tb_yarvi_alu_arb;
    logic clock;
    logic reset_n;
    int   asserts;
    int   failures;

    yarvi_alu_arb_if #(.XLEN(32)) bus ();

    yarvi_alu_arb #(
        .XLEN(32)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req(input int i, input logic valid, input logic insn30,
                             input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (i == 0) begin
            bus.req0_valid = valid; bus.req0_insn30 = insn30; bus.req0_funct3 = f3;
            bus.req0_op1 = a; bus.req0_op2 = b;
        end else begin
            bus.req1_valid = valid; bus.req1_insn30 = insn30; bus.req1_funct3 = f3;
            bus.req1_op1 = a; bus.req1_op2 = b;
        end
    endtask

    // Reference arithmetic written from the instruction definitions.
    function automatic logic [31:0] alu_ref(input logic insn30, input logic [2:0] f3,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ext;
        int sh;
        sh = int'(b[4:0]);
        case (f3)
            3'd0: return insn30 ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                ext = insn30 ? {{32{a[31]}}, a} : {32'd0, a};
                ext = ext >> sh;
                return ext[31:0];
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    logic        p_valid  [2];
    logic        p_insn30 [2];
    logic [2:0]  p_f3     [2];
    logic [31:0] p_op1    [2];
    logic [31:0] p_op2    [2];
    logic        rr       [2];
    logic        elig     [2];
    logic        g        [2];
    logic        full     [2];
    logic [31:0] data     [2];
    int          wait_cnt [2];
    logic        prio_m;
    logic        obs_ready;
    logic        obs_valid;
    logic [31:0] obs_result;

    initial begin
        asserts  = 0;
        failures = 0;
        reset_n  = 1'b0;
        drive_req(0, 1'b1, 1'b0, 3'd0, 32'd1, 32'd1);
        drive_req(1, 1'b1, 1'b0, 3'd0, 32'd2, 32'd2);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;

        // Reset values, with both requests pending so ready masking is exercised.
        #3;
        check("reset_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        check("reset_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        check("reset_rsp0_result", bus.rsp0_result, 32'd0);
        check("reset_rsp1_result", bus.rsp1_result, 32'd0);
        check("reset_req0_ready", 32'(bus.req0_ready), 32'd0);
        check("reset_req1_ready", 32'(bus.req1_ready), 32'd0);

        // Single requester ADD 5+3.
        tick();
        reset_n = 1'b1;
        drive_req(0, 1'b1, 1'b0, 3'd0, 32'd5, 32'd3);
        drive_req(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #1;
        check("single_req0_ready", 32'(bus.req0_ready), 32'd1);
        check("single_req1_ready", 32'(bus.req1_ready), 32'd0);
        tick();
        check("single_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        check("single_rsp0_result", bus.rsp0_result, 32'd8);

        // Hold the result, then reset asynchronously between clock edges.
        drive_req(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        bus.rsp0_ready = 1'b0;
        tick();
        check("hold_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        check("hold_rsp0_result", bus.rsp0_result, 32'd8);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        check("async_rst_rsp0_result", bus.rsp0_result, 32'd0);

        // Contention after reset: grants must start at requester 0 and alternate.
        tick();
        reset_n = 1'b1;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        drive_req(0, 1'b1, 1'b1, 3'd0, 32'd10, 32'd3);
        drive_req(1, 1'b1, 1'b1, 3'd5, 32'h8000_0000, 32'd4);
        #1;
        check("cont_c1_g0", 32'(bus.req0_ready), 32'd1);
        check("cont_c1_g1", 32'(bus.req1_ready), 32'd0);
        tick();
        check("cont_c2_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        check("cont_c2_rsp0_result", bus.rsp0_result, 32'd7);
        check("cont_c2_g0", 32'(bus.req0_ready), 32'd0);
        check("cont_c2_g1", 32'(bus.req1_ready), 32'd1);
        tick();
        check("cont_c3_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
        check("cont_c3_rsp1_result", bus.rsp1_result, 32'hF800_0000);
        check("cont_c3_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        check("cont_c3_g0", 32'(bus.req0_ready), 32'd1);
        check("cont_c3_g1", 32'(bus.req1_ready), 32'd0);
        tick();
        check("cont_c4_rsp0_result", bus.rsp0_result, 32'd7);
        check("cont_c4_g0", 32'(bus.req0_ready), 32'd0);
        check("cont_c4_g1", 32'(bus.req1_ready), 32'd1);
        tick();

        // Backpressure on slot 1 must not block requester 0.
        bus.rsp1_ready = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            check("bp_req1_ready", 32'(bus.req1_ready), 32'd0);
            check("bp_req0_ready", 32'(bus.req0_ready), 32'd1);
            check("bp_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
            check("bp_rsp1_result", bus.rsp1_result, 32'hF800_0000);
            tick();
        end

        // Drain and refill slot 0 in the same cycle with SLTU 1 < 0xFFFFFFFF.
        drive_req(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive_req(0, 1'b1, 1'b0, 3'd3, 32'd1, 32'hFFFF_FFFF);
        #1;
        check("refill_rsp0_valid_before", 32'(bus.rsp0_valid), 32'd1);
        check("refill_req0_ready", 32'(bus.req0_ready), 32'd1);
        tick();
        check("refill_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        check("refill_rsp0_result", bus.rsp0_result, 32'd1);

        // Fresh reset so the random phase starts from a known model state.
        drive_req(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            p_valid[i]  = 1'b0;
            full[i]     = 1'b0;
            data[i]     = 32'd0;
            wait_cnt[i] = 0;
        end
        prio_m = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!p_valid[i]) begin
                    p_valid[i]  = ($urandom_range(0, 3) != 0);
                    p_insn30[i] = 1'($urandom_range(0, 1));
                    p_f3[i]     = 3'($urandom_range(0, 7));
                    p_op1[i]    = rand_operand();
                    p_op2[i]    = rand_operand();
                end
                rr[i] = ($urandom_range(0, 3) != 0);
                drive_req(i, p_valid[i], p_insn30[i], p_f3[i], p_op1[i], p_op2[i]);
            end
            bus.rsp0_ready = rr[0];
            bus.rsp1_ready = rr[1];
            #1;
            for (int i = 0; i < 2; i++) begin
                elig[i] = p_valid[i] && (!full[i] || rr[i]);
            end
            g[0] = elig[0] && (!elig[1] || !prio_m);
            g[1] = elig[1] && (!elig[0] || prio_m);
            for (int i = 0; i < 2; i++) begin
                obs_ready  = (i == 0) ? bus.req0_ready  : bus.req1_ready;
                obs_valid  = (i == 0) ? bus.rsp0_valid  : bus.rsp1_valid;
                obs_result = (i == 0) ? bus.rsp0_result : bus.rsp1_result;
                check($sformatf("rand_ready%0d", i), 32'(obs_ready), 32'(g[i]));
                check($sformatf("rand_rsp_valid%0d", i), 32'(obs_valid), 32'(full[i]));
                if (full[i]) begin
                    check($sformatf("rand_rsp_result%0d", i), obs_result, data[i]);
                end
                if (elig[i] && !obs_ready) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                check($sformatf("rand_fairness%0d", i), 32'(wait_cnt[i] > 1), 32'd0);
            end
            for (int i = 0; i < 2; i++) begin
                if (g[i]) begin
                    full[i]    = 1'b1;
                    data[i]    = alu_ref(p_insn30[i], p_f3[i], p_op1[i], p_op2[i]);
                    p_valid[i] = 1'b0;
                end else if (full[i] && rr[i]) begin
                    full[i] = 1'b0;
                end
            end
            if (g[0]) prio_m = 1'b1;
            else if (g[1]) prio_m = 1'b0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
